fsb_cycle: RTL

- Front-side-bus cycle controller for the MC68HC000 accelerator.
- Sits directly upstream of the SRAM/flash strobe decoder:
  - decodes the CPU address into RAMCS / ROMCS / EXTCS;
  - inserts per-region wait states and terminates each cycle with nDTACK, or nBERR on an external timeout.
- Owns the boot ROM overlay flag.

---
 rtl/fsb_pkg.sv | 22 ++
 rtl/fsb_decode.sv | 20 ++
 rtl/fsb_cycle.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fsb_pkg.sv
// rtl/fsb_pkg.sv - shared types and constants for the front-side-bus cycle controller
package fsb_pkg;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_ROM,
    REG_EXT
  } region_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RECOVER
  } state_e;

  localparam logic [3:0] ROM_BASE_NIB = 4'h4;
  localparam logic [3:0] RAM_TOP_NIB  = 4'h3;
  localparam int         CNT_W        = 8;

endpackage

// File: rtl/fsb_decode.sv
// rtl/fsb_decode.sv - combinational address-to-region decode with boot overlay
module fsb_decode
  import fsb_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic       overlay_i,
  output logic [1:0] region_o
);

  // Low 4 MB is ROM while the boot overlay is active, RAM otherwise.
  always_comb begin
    region_o = REG_EXT;
    if (a_i <= RAM_TOP_NIB) begin
      region_o = overlay_i ? REG_ROM : REG_RAM;
    end else if (a_i == ROM_BASE_NIB) begin
      region_o = REG_ROM;
    end
  end

endmodule

// File: rtl/fsb_cycle.sv
// rtl/fsb_cycle.sv - 68000 bus cycle FSM: chip selects, wait states, DTACK/BERR, overlay
module fsb_cycle
  import fsb_pkg::*;
#(
  parameter int RAM_WS  = 0,
  parameter int ROM_WS  = 2,
  parameter int BERR_TO = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       nAS,
  input  logic       nWE,
  input  logic [3:0] A,
  input  logic       nEXTDTACK,
  output logic       RAMCS,
  output logic       ROMCS,
  output logic       EXTCS,
  output logic       nDTACK,
  output logic       nBERR,
  output logic       OVERLAY
);

  localparam logic [CNT_W-1:0] RAM_WS_C  = CNT_W'(RAM_WS);
  localparam logic [CNT_W-1:0] ROM_WS_C  = CNT_W'(ROM_WS);
  localparam logic [CNT_W-1:0] BERR_TO_C = CNT_W'(BERR_TO);

  state_e           state_q;
  region_e          region_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ramcs_q;
  logic             romcs_q;
  logic             extcs_q;
  logic             dtack_n_q;
  logic             berr_n_q;
  logic             overlay_q;

  logic [1:0]       dec_region;
  logic [CNT_W-1:0] ws_new;
  logic [CNT_W-1:0] ws_cur;
  logic             ws_hit;
  logic             to_hit;

  // R/W is only meaningful to the downstream strobe decoder.
  logic             unused_nwe;
  assign unused_nwe = nWE;

  fsb_decode u_decode (
    .a_i       (A),
    .overlay_i (overlay_q),
    .region_o  (dec_region)
  );

  // Saturating next count plus wait-state / timeout comparisons against it.
  always_comb begin
    cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    ws_new = (dec_region == REG_RAM) ? RAM_WS_C : ROM_WS_C;
    ws_cur = (region_q == REG_RAM) ? RAM_WS_C : ROM_WS_C;
    ws_hit = (cnt_d >= ws_cur);
    to_hit = (cnt_d >= BERR_TO_C);
  end

  // Cycle FSM with registered chip selects, acknowledges and overlay flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RECOVER;
      region_q  <= REG_NONE;
      cnt_q     <= '0;
      ramcs_q   <= 1'b0;
      romcs_q   <= 1'b0;
      extcs_q   <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      overlay_q <= 1'b1;
    end else begin
      case (state_q)
        RECOVER: begin
          if (nAS) state_q <= IDLE;
        end
        IDLE: begin
          if (!nAS) begin
            region_q <= region_e'(dec_region);
            ramcs_q  <= (dec_region == REG_RAM);
            romcs_q  <= (dec_region == REG_ROM);
            extcs_q  <= (dec_region == REG_EXT);
            cnt_q    <= '0;
            // Overlay drops on first access to the real ROM window; the
            // current cycle already used the old value for its decode.
            if (A == ROM_BASE_NIB && dec_region == REG_ROM) overlay_q <= 1'b0;
            if (dec_region != REG_EXT && ws_new == '0) begin
              dtack_n_q <= 1'b0;
              state_q   <= ACK;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (nAS) begin
            region_q  <= REG_NONE;
            ramcs_q   <= 1'b0;
            romcs_q   <= 1'b0;
            extcs_q   <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (region_q == REG_EXT) begin
              // External DTACK takes precedence over a coincident timeout.
              if (!nEXTDTACK) begin
                dtack_n_q <= 1'b0;
                state_q   <= ACK;
              end else if (to_hit) begin
                berr_n_q <= 1'b0;
                state_q  <= ACK;
              end
            end else if (ws_hit) begin
              dtack_n_q <= 1'b0;
              state_q   <= ACK;
            end
          end
        end
        ACK: begin
          if (nAS) begin
            region_q  <= REG_NONE;
            ramcs_q   <= 1'b0;
            romcs_q   <= 1'b0;
            extcs_q   <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= RECOVER;
        end
      endcase
    end
  end

  assign RAMCS   = ramcs_q;
  assign ROMCS   = romcs_q;
  assign EXTCS   = extcs_q;
  assign nDTACK  = dtack_n_q;
  assign nBERR   = berr_n_q;
  assign OVERLAY = overlay_q;

endmodule
